// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with buffered load returns onto the register file write port
// and tracks outstanding loads in an 8-entry pending scoreboard.
module wb_stage #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_rd,
  input  logic [15:0] ld_data,
  input  logic        pend_set,
  input  logic [2:0]  pend_rd,
  output logic [7:0]  pending,
  output logic        gpr_we,
  output logic [2:0]  gpr_ws,
  output logic [15:0] gpr_wd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [2:0]       fifo_rd   [DEPTH];
  logic [15:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve;

  logic             fifo_nonempty;
  logic             alu_take_p0;
  logic             pop_p0;
  logic             push_p0;
  logic [2:0]       head_rd_p0;
  logic [15:0]      head_data_p0;
  logic [7:0]       set_mask_p0;
  logic [7:0]       clr_mask_p0;
  logic [CNT_W-1:0] count_nxt;
  logic [ST_W-1:0]  starve_nxt;

  assign fifo_nonempty = (count != '0);
  assign ld_ready      = (count != CNT_W'(DEPTH));
  assign alu_ready     = !((starve == ST_W'(STARVE_MAX)) && fifo_nonempty);

  // Selection stage: ALU has priority unless the starvation limit has stalled it
  always_comb begin
    alu_take_p0  = alu_valid && alu_ready;
    pop_p0       = !alu_take_p0 && fifo_nonempty;
    push_p0      = ld_valid && ld_ready;
    head_rd_p0   = fifo_rd[rd_ptr];
    head_data_p0 = fifo_data[rd_ptr];
    set_mask_p0  = pend_set ? (8'b1 << pend_rd) : 8'h00;
    clr_mask_p0  = pop_p0 ? (8'b1 << head_rd_p0) : 8'h00;

    count_nxt = count;
    if (push_p0 && !pop_p0)
      count_nxt = count + 1'b1;
    else if (!push_p0 && pop_p0)
      count_nxt = count - 1'b1;

    starve_nxt = starve;
    if (pop_p0 || !fifo_nonempty)
      starve_nxt = '0;
    else if (alu_take_p0 && starve != ST_W'(STARVE_MAX))
      starve_nxt = starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // Commit stage: register file write port, FIFO control and scoreboard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpr_we  <= 1'b0;
      gpr_ws  <= 3'd0;
      gpr_wd  <= 16'h0000;
      pending <= 8'h00;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      starve  <= '0;
    end else begin
      gpr_we <= alu_take_p0 || pop_p0;
      if (alu_take_p0) begin
        gpr_ws <= alu_rd;
        gpr_wd <= alu_data;
      end else if (pop_p0) begin
        gpr_ws <= head_rd_p0;
        gpr_wd <= head_data_p0;
      end
      // set is applied after clear so a same-cycle set of a retiring register wins
      pending <= (pending & ~clr_mask_p0) | set_mask_p0;
      count   <= count_nxt;
      starve  <= starve_nxt;
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, ALU path, load path, contention/starvation,
// scoreboard set/clear collision and reset with a full FIFO.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_rd;
  logic [15:0] ld_data;
  logic        pend_set;
  logic [2:0]  pend_rd;
  logic [7:0]  pending;
  logic        gpr_we;
  logic [2:0]  gpr_ws;
  logic [15:0] gpr_wd;

  int checks = 0;
  int errors = 0;

  wb_stage #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .pend_set(pend_set), .pend_rd(pend_rd), .pending(pending),
    .gpr_we(gpr_we), .gpr_ws(gpr_ws), .gpr_wd(gpr_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 3'd0; alu_data = 16'h0000;
    ld_valid = 1'b0;  ld_rd = 3'd0;  ld_data = 16'h0000;
    pend_set = 1'b0;  pend_rd = 3'd0;
  endtask

  logic [15:0] t4_alu_rdy;
  logic [15:0] t4_ld_rdy;
  logic [15:0] alu_cnt;
  logic [2:0]  exp_ws;
  logic [15:0] exp_wd;

  initial begin
    // T1: reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'($urandom); alu_rd = 3'($urandom); alu_data = 16'($urandom);
      ld_valid = 1'($urandom);  ld_rd = 3'($urandom);  ld_data = 16'($urandom);
      pend_set = 1'($urandom);  pend_rd = 3'($urandom);
      step();
    end
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_we", 32'(gpr_we), 32'd0);
    chk("rst_ws", 32'(gpr_ws), 32'd0);
    chk("rst_wd", 32'(gpr_wd), 32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    step();
    chk("rst_idle_we", 32'(gpr_we), 32'd0);

    // T2: ALU path
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'hBEEF;
    step();
    idle();
    chk("alu_we", 32'(gpr_we), 32'd1);
    chk("alu_ws", 32'(gpr_ws), 32'd3);
    chk("alu_wd", 32'(gpr_wd), 32'hBEEF);
    step();
    chk("alu_we_off", 32'(gpr_we), 32'd0);
    chk("alu_ws_hold", 32'(gpr_ws), 32'd3);
    chk("alu_wd_hold", 32'(gpr_wd), 32'hBEEF);

    // T3: load with idle ALU
    pend_set = 1'b1; pend_rd = 3'd5;
    step();
    idle();
    chk("ld_pend_set", 32'(pending), 32'h20);
    ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 16'h1234;
    step();
    idle();
    chk("ld_no_bypass_we", 32'(gpr_we), 32'd0);
    chk("ld_pend_hold", 32'(pending), 32'h20);
    step();
    chk("ld_we", 32'(gpr_we), 32'd1);
    chk("ld_ws", 32'(gpr_ws), 32'd5);
    chk("ld_wd", 32'(gpr_wd), 32'h1234);
    chk("ld_pend_clr", 32'(pending), 32'h00);
    step();
    chk("ld_we_off", 32'(gpr_we), 32'd0);

    // T4: ALU stuck valid with three loads competing
    t4_alu_rdy = 16'h7BDF;
    t4_ld_rdy  = 16'hF843;
    alu_cnt    = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA000 + alu_cnt;
      ld_valid  = (c <= 6);
      ld_rd     = (c == 0) ? 3'd4 : (c == 1) ? 3'd5 : 3'd6;
      ld_data   = 16'h4000 | 16'(ld_rd);
      #1;
      chk($sformatf("t4_alu_ready_c%0d", c), 32'(alu_ready), 32'(t4_alu_rdy[c]));
      chk($sformatf("t4_ld_ready_c%0d", c), 32'(ld_ready), 32'(t4_ld_rdy[c]));
      if (c == 5)       begin exp_ws = 3'd4; exp_wd = 16'h4004; end
      else if (c == 10) begin exp_ws = 3'd5; exp_wd = 16'h4005; end
      else if (c == 15) begin exp_ws = 3'd6; exp_wd = 16'h4006; end
      else              begin exp_ws = 3'd1; exp_wd = 16'hA000 + alu_cnt; end
      if (t4_alu_rdy[c]) alu_cnt = alu_cnt + 16'd1;
      @(posedge clk);
      #1;
      chk($sformatf("t4_we_c%0d", c), 32'(gpr_we), 32'd1);
      chk($sformatf("t4_ws_c%0d", c), 32'(gpr_ws), 32'(exp_ws));
      chk($sformatf("t4_wd_c%0d", c), 32'(gpr_wd), 32'(exp_wd));
    end
    idle();
    step();
    chk("t4_drained_we", 32'(gpr_we), 32'd0);

    // T5: pend_set collides with the retiring load to the same register
    pend_set = 1'b1; pend_rd = 3'd2;
    step();
    idle();
    ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 16'h2222;
    step();
    idle();
    pend_set = 1'b1; pend_rd = 3'd2;
    step();
    idle();
    chk("t5_we", 32'(gpr_we), 32'd1);
    chk("t5_ws", 32'(gpr_ws), 32'd2);
    chk("t5_wd", 32'(gpr_wd), 32'h2222);
    chk("t5_set_wins", 32'(pending), 32'h04);
    step();
    chk("t5_pend_hold", 32'(pending), 32'h04);

    // T6: reset with a full FIFO
    pend_set = 1'b1; pend_rd = 3'd1;
    step();
    idle();
    chk("t6_pending", 32'(pending), 32'h06);
    alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'h7777;
    ld_valid = 1'b1;  ld_rd = 3'd1;  ld_data = 16'h1111;
    step();
    ld_rd = 3'd2; ld_data = 16'h2222;
    step();
    idle();
    #1;
    chk("t6_full", 32'(ld_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_pending", 32'(pending), 32'h00);
    chk("t6_rst_we", 32'(gpr_we), 32'd0);
    chk("t6_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("t6_rst_alu_ready", 32'(alu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_no_we_%0d", i), 32'(gpr_we), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
